// File: rtl/rn_axil_reg_pkg.sv
// Shared definitions for the AXI4-Lite register slave: address map, response codes,
// FSM state encodings and the address decoder.
package rn_axil_reg_pkg;

  localparam logic [11:0] OFF_RW_BASE    = 12'h000;
  localparam logic [11:0] OFF_RO_BASE    = 12'h100;
  localparam logic [11:0] OFF_INT_STATUS = 12'h200;
  localparam logic [11:0] OFF_INT_ENABLE = 12'h204;
  localparam logic [11:0] OFF_VERSION    = 12'h208;
  localparam logic [31:0] VERSION_VAL    = 32'h0001_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  typedef enum logic [2:0] {
    RGN_RW, RGN_RO, RGN_INT_STATUS, RGN_INT_ENABLE, RGN_VERSION, RGN_NONE
  } region_e;

  typedef struct packed {
    region_e    region;
    logic [5:0] index;
    logic       valid;
  } decode_t;

  // Unmapped holes and out-of-window addresses decode to RGN_NONE with valid=0.
  function automatic decode_t addr_decode(input logic [31:0] addr, input int num_rw,
                                          input int num_ro);
    decode_t    d;
    logic [11:0] off;
    off      = {addr[11:2], 2'b00};
    d.region = RGN_NONE;
    d.index  = addr[7:2];
    d.valid  = 1'b0;
    if (addr[31:12] == 20'd0) begin
      if (off[11:8] == OFF_RW_BASE[11:8]) begin
        d.region = RGN_RW;
        d.valid  = (int'(d.index) < num_rw);
      end else if (off[11:8] == OFF_RO_BASE[11:8]) begin
        d.region = RGN_RO;
        d.valid  = (int'(d.index) < num_ro);
      end else if (off == OFF_INT_STATUS) begin
        d.region = RGN_INT_STATUS;
        d.valid  = 1'b1;
      end else if (off == OFF_INT_ENABLE) begin
        d.region = RGN_INT_ENABLE;
        d.valid  = 1'b1;
      end else if (off == OFF_VERSION) begin
        d.region = RGN_VERSION;
        d.valid  = 1'b1;
      end
    end
    if (!d.valid) d.region = RGN_NONE;
    return d;
  endfunction

endpackage

// File: rtl/rn_axil_reg_slave.sv
// AXI4-Lite register slave: RW control, RO status, W1C interrupt status/enable, version.
// Write commits the cycle after AW+W captured (B held until bready); read data 1 cycle after AR.
module rn_axil_reg_slave
  import rn_axil_reg_pkg::*;
#(
  parameter int C_NUM_RW = 8,
  parameter int C_NUM_RO = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_axil_awvalid,
  input  logic [31:0]           s_axil_awaddr,
  output logic                  s_axil_awready,
  input  logic                  s_axil_wvalid,
  input  logic [31:0]           s_axil_wdata,
  output logic                  s_axil_wready,
  output logic                  s_axil_bvalid,
  output logic [1:0]            s_axil_bresp,
  input  logic                  s_axil_bready,
  input  logic                  s_axil_arvalid,
  input  logic [31:0]           s_axil_araddr,
  output logic                  s_axil_arready,
  output logic                  s_axil_rvalid,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  input  logic                  s_axil_rready,
  output logic [32*C_NUM_RW-1:0] ctrl_reg,
  input  logic [32*C_NUM_RO-1:0] status_reg,
  input  logic [31:0]           event_in,
  output logic                  irq
);

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  logic    live_q;
  logic    aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [C_NUM_RW-1:0][31:0] ctrl_q, ctrl_d;
  logic [31:0] int_status_q, int_status_d, int_enable_q, int_enable_d;
  logic        irq_q, irq_d;
  logic [31:0] w1c_mask, rd_val;
  logic        wr_commit;
  decode_t     wdec, rdec;

  // live_q keeps both address channels closed until the first cycle out of reset.
  assign s_axil_awready = live_q && (wstate_q == W_IDLE) && !aw_got_q;
  assign s_axil_wready  = live_q && (wstate_q == W_IDLE) && !w_got_q;
  assign s_axil_bvalid  = (wstate_q == W_RESP);
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = live_q && (rstate_q == R_IDLE);
  assign s_axil_rvalid  = (rstate_q == R_DATA);
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign ctrl_reg       = ctrl_q;
  assign irq            = irq_q;

  always_comb begin
    wstate_d     = wstate_q;
    aw_got_d     = aw_got_q;
    w_got_d      = w_got_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    bresp_d      = bresp_q;
    ctrl_d       = ctrl_q;
    int_enable_d = int_enable_q;
    w1c_mask     = '0;
    wdec         = addr_decode(awaddr_q, C_NUM_RW, C_NUM_RO);
    wr_commit    = (wstate_q == W_IDLE) && aw_got_q && w_got_q;
    if (s_axil_awvalid && s_axil_awready) begin
      aw_got_d = 1'b1;
      awaddr_d = s_axil_awaddr;
    end
    if (s_axil_wvalid && s_axil_wready) begin
      w_got_d = 1'b1;
      wdata_d = s_axil_wdata;
    end
    case (wstate_q)
      W_IDLE: begin
        if (wr_commit) begin
          wstate_d = W_RESP;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          bresp_d  = RESP_OKAY;
          case (wdec.region)
            RGN_RW: begin
              for (int i = 0; i < C_NUM_RW; i++)
                if (wdec.index == 6'(i)) ctrl_d[i] = wdata_q;
            end
            RGN_INT_STATUS: w1c_mask = wdata_q;
            RGN_INT_ENABLE: int_enable_d = wdata_q;
            default: bresp_d = RESP_SLVERR;
          endcase
        end
      end
      W_RESP: begin
        if (s_axil_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    // An event on the same cycle as its W1C clear wins.
    int_status_d = (int_status_q & ~w1c_mask) | event_in;
    irq_d        = |(int_status_q & int_enable_q);
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rd_val   = '0;
    rdec     = addr_decode(s_axil_araddr, C_NUM_RW, C_NUM_RO);
    case (rdec.region)
      RGN_RW: begin
        for (int i = 0; i < C_NUM_RW; i++)
          if (rdec.index == 6'(i)) rd_val = ctrl_q[i];
      end
      RGN_RO: begin
        for (int i = 0; i < C_NUM_RO; i++)
          if (rdec.index == 6'(i)) rd_val = status_reg[32*i +: 32];
      end
      RGN_INT_STATUS: rd_val = int_status_q;
      RGN_INT_ENABLE: rd_val = int_enable_q;
      RGN_VERSION:    rd_val = VERSION_VAL;
      default:        rd_val = '0;
    endcase
    case (rstate_q)
      R_IDLE: begin
        if (s_axil_arvalid && s_axil_arready) begin
          rstate_d = R_DATA;
          rdata_d  = rd_val;
          rresp_d  = rdec.valid ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (s_axil_rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q     <= W_IDLE;
      rstate_q     <= R_IDLE;
      live_q       <= 1'b0;
      aw_got_q     <= 1'b0;
      w_got_q      <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      bresp_q      <= '0;
      rresp_q      <= '0;
      rdata_q      <= '0;
      ctrl_q       <= '0;
      int_status_q <= '0;
      int_enable_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      live_q       <= 1'b1;
      aw_got_q     <= aw_got_d;
      w_got_q      <= w_got_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      bresp_q      <= bresp_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      ctrl_q       <= ctrl_d;
      int_status_q <= int_status_d;
      int_enable_q <= int_enable_d;
      irq_q        <= irq_d;
    end
  end

endmodule

// File: tb/tb_rn_axil_reg_slave.sv
// Directed bench for rn_axil_reg_slave; responses are matched against a queue of
// expectations pushed when each transaction is issued.
module tb_rn_axil_reg_slave;

  logic         aclk, areset;
  logic         s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [31:0]  s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
  logic         s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic         s_axil_rvalid, s_axil_rready;
  logic [1:0]   s_axil_bresp, s_axil_rresp;
  logic [255:0] ctrl_reg, status_reg;
  logic [31:0]  event_in;
  logic         irq;

  int total = 0;
  int bad   = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [7:0][31:0] ctrl_m;
  logic irq_at_b;

  rn_axil_reg_slave #(.C_NUM_RW(8), .C_NUM_RO(8)) dut (
    .aclk(aclk), .areset(areset),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awaddr(s_axil_awaddr), .s_axil_awready(s_axil_awready),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wdata(s_axil_wdata), .s_axil_wready(s_axil_wready),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bresp(s_axil_bresp), .s_axil_bready(s_axil_bready),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_araddr(s_axil_araddr), .s_axil_arready(s_axil_arready),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rready(s_axil_rready),
    .ctrl_reg(ctrl_reg), .status_reg(status_reg), .event_in(event_in), .irq(irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW. ev pulses on the commit cycle.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input int lead,
                           input logic [1:0] exp_resp, input logic [31:0] ev);
    bit aw_pend = 1'b1, w_pend = 1'b1, hs_aw, hs_w;
    int aw_at, w_at, c;
    logic [1:0] e;
    aw_at = (lead < 0) ? -lead : 0;
    w_at  = (lead > 0) ? lead : 0;
    bq.push_back(exp_resp);
    c = 0;
    while ((aw_pend || w_pend) && c < 50) begin
      s_axil_awvalid = aw_pend && (c >= aw_at);
      s_axil_awaddr  = addr;
      s_axil_wvalid  = w_pend && (c >= w_at);
      s_axil_wdata   = data;
      hs_aw = s_axil_awvalid && s_axil_awready;
      hs_w  = s_axil_wvalid && s_axil_wready;
      tick();
      if (hs_aw) aw_pend = 1'b0;
      if (hs_w) w_pend = 1'b0;
      c++;
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    check("aw_w_accept", 256'({aw_pend, w_pend}), 256'(2'b00));
    event_in      = ev;
    s_axil_bready = 1'b1;
    c = 0;
    while (!s_axil_bvalid && c < 20) begin
      tick();
      event_in = '0;
      c++;
    end
    event_in = '0;
    irq_at_b = irq;
    check("bvalid_seen", 256'(s_axil_bvalid), 256'(1'b1));
    e = bq.pop_front();
    check("bresp", 256'(s_axil_bresp), 256'(e));
    tick();
    s_axil_bready = 1'b0;
    check("bvalid_drop", 256'(s_axil_bvalid), 256'(1'b0));
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int hold);
    int c;
    logic [33:0]  e;
    logic [255:0] st;
    rq.push_back({exp_resp, exp_data});
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = addr;
    c = 0;
    while (!s_axil_arready && c < 50) begin
      tick();
      c++;
    end
    tick();
    s_axil_arvalid = 1'b0;
    check("rvalid_1cyc", 256'(s_axil_rvalid), 256'(1'b1));
    e = rq.pop_front();
    check("rdata", 256'(s_axil_rdata), 256'(e[31:0]));
    check("rresp", 256'(s_axil_rresp), 256'(e[33:32]));
    // Status changes after acceptance must not leak into the held response.
    st = status_reg;
    status_reg = ~st;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rdata_hold", 256'({s_axil_rvalid, s_axil_rdata}), 256'({1'b1, e[31:0]}));
    end
    s_axil_rready = 1'b1;
    tick();
    s_axil_rready = 1'b0;
    status_reg = st;
    check("rvalid_drop", 256'(s_axil_rvalid), 256'(1'b0));
  endtask

  initial begin
    areset = 1'b1;
    s_axil_awvalid = 1'b0; s_axil_awaddr = '0; s_axil_wvalid = 1'b0; s_axil_wdata = '0;
    s_axil_bready = 1'b0; s_axil_arvalid = 1'b0; s_axil_araddr = '0; s_axil_rready = 1'b0;
    event_in = '0;
    ctrl_m = '0;
    for (int i = 0; i < 8; i++) status_reg[32*i +: 32] = 32'hA000_0000 + i;
    status_reg[63:32] = 32'h1234_5678;
    repeat (3) tick();
    check("rst_outs", 256'({s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready,
                            s_axil_rvalid, irq}), 256'(6'b0));
    check("rst_data", 256'({s_axil_bresp, s_axil_rresp, s_axil_rdata}), 256'(0));
    check("rst_ctrl", ctrl_reg, 256'(0));
    areset = 1'b0;
    tick();
    check("rdy_after_rst", 256'({s_axil_awready, s_axil_wready, s_axil_arready}), 256'(3'b111));

    axi_write(32'h000, 32'hDEAD_BEEF, 2, 2'b00, 32'h0);
    ctrl_m[0] = 32'hDEAD_BEEF;
    check("ctrl0", 256'(ctrl_reg[31:0]), 256'(32'hDEAD_BEEF));
    axi_read(32'h000, 32'hDEAD_BEEF, 2'b00, 0);
    axi_write(32'h004, 32'h1111_2222, -1, 2'b00, 32'h0);
    ctrl_m[1] = 32'h1111_2222;
    axi_write(32'h01C, 32'h7777_0001, 0, 2'b00, 32'h0);
    ctrl_m[7] = 32'h7777_0001;
    check("ctrl_all", ctrl_reg, ctrl_m);
    axi_read(32'h007, 32'h1111_2222, 2'b00, 0);

    axi_read(32'h104, 32'h1234_5678, 2'b00, 5);
    axi_read(32'h11C, 32'hA000_0007, 2'b00, 1);
    axi_read(32'h208, 32'h0001_0000, 2'b00, 0);

    axi_write(32'h100, 32'hAAAA_5555, 0, 2'b10, 32'h0);
    check("ctrl_after_ro_wr", ctrl_reg, ctrl_m);
    axi_read(32'h3FC, 32'h0, 2'b10, 0);
    axi_write(32'h020, 32'hBBBB_0000, 1, 2'b10, 32'h0);
    axi_write(32'h208, 32'hCCCC_0000, 0, 2'b10, 32'h0);
    axi_write(32'h8000_0000, 32'hDDDD_0000, 0, 2'b10, 32'h0);
    check("ctrl_after_err", ctrl_reg, ctrl_m);
    axi_read(32'h0000_1000, 32'h0, 2'b10, 0);
    axi_read(32'h120, 32'h0, 2'b10, 0);

    event_in = 32'h5;
    tick();
    event_in = '0;
    tick();
    check("irq_masked", 256'(irq), 256'(1'b0));
    axi_write(32'h204, 32'h4, 0, 2'b00, 32'h0);
    check("irq_set", 256'(irq), 256'(1'b1));
    axi_read(32'h200, 32'h5, 2'b00, 0);
    axi_write(32'h200, 32'h4, 0, 2'b00, 32'h4);
    check("irq_hold_evt", 256'(irq), 256'(1'b1));
    axi_read(32'h200, 32'h5, 2'b00, 0);
    axi_write(32'h200, 32'h4, 1, 2'b00, 32'h0);
    check("irq_lag", 256'(irq_at_b), 256'(1'b1));
    check("irq_clear", 256'(irq), 256'(1'b0));
    axi_read(32'h200, 32'h1, 2'b00, 0);
    axi_read(32'h204, 32'h4, 2'b00, 0);

    fork
      axi_write(32'h004, 32'h3333_4444, 0, 2'b00, 32'h0);
      begin
        tick();
        axi_read(32'h004, 32'h1111_2222, 2'b00, 0);
      end
    join
    ctrl_m[1] = 32'h3333_4444;
    axi_read(32'h004, 32'h3333_4444, 2'b00, 0);

    s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h00C;
    s_axil_wvalid = 1'b1; s_axil_wdata = 32'h5A5A_5A5A;
    s_axil_arvalid = 1'b1; s_axil_araddr = 32'h000;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    tick();
    check("pre_rst_valids", 256'({s_axil_bvalid, s_axil_rvalid}), 256'(2'b11));
    areset = 1'b1;
    tick();
    ctrl_m = '0;
    check("rst_valids", 256'({s_axil_bvalid, s_axil_rvalid, irq}), 256'(3'b000));
    check("rst_ctrl2", ctrl_reg, 256'(0));
    areset = 1'b0;
    tick();
    check("rdy_after_rst2", 256'({s_axil_awready, s_axil_arready}), 256'(2'b11));
    axi_write(32'h008, 32'hCAFE_F00D, 1, 2'b00, 32'h0);
    ctrl_m[2] = 32'hCAFE_F00D;
    check("ctrl_post_rst", ctrl_reg, ctrl_m);
    axi_read(32'h008, 32'hCAFE_F00D, 2'b00, 2);
    axi_read(32'h204, 32'h0, 2'b00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
